// File: rtl/dvi_scanout_timing_pkg.sv
// Shared raster constants, pixel/FSM types and the colour-bar lookup
// used by the DVI scan-out stage.
package dvi_scanout_timing_pkg;

  localparam int DVI_H_ACTIVE = 640;
  localparam int DVI_H_FP     = 16;
  localparam int DVI_H_SYNC   = 96;
  localparam int DVI_H_BP     = 48;
  localparam int DVI_V_ACTIVE = 480;
  localparam int DVI_V_FP     = 10;
  localparam int DVI_V_SYNC   = 2;
  localparam int DVI_V_BP     = 33;

  localparam logic        DVI_SYNC_POL        = 1'b0;
  localparam logic [23:0] DVI_UNDERFLOW_COLOR = 24'hFF00FF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    STREAM
  } scanout_state_t;

  // Bars W,Y,C,G,M,R,B,K map to per-channel bits of the bar index.
  function automatic rgb_t bar_color(input logic [2:0] bar);
    rgb_t c;
    c.r = {8{~bar[1]}};
    c.g = {8{~bar[2]}};
    c.b = {8{~bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/dvi_scanout_timing_if.sv
// Framebuffer read-FIFO port (first-word-fall-through head plus pop)
// between the framebuffer block and the scan-out stage.
interface dvi_scanout_timing_if;

  logic [31:0] framebuffer_data;
  logic        framebuffer_valid;
  logic        framebuffer_pull;

  modport master (
    output framebuffer_data,
    output framebuffer_valid,
    input  framebuffer_pull
  );

  modport slave (
    input  framebuffer_data,
    input  framebuffer_valid,
    output framebuffer_pull
  );

endinterface

// File: rtl/dvi_scanout_timing_counter.sv
// Free-running horizontal/vertical raster counters with active-area
// and sync-window decode.
module dvi_scanout_timing_counter
  import dvi_scanout_timing_pkg::*;
#(
  parameter int H_ACTIVE = DVI_H_ACTIVE,
  parameter int H_FP     = DVI_H_FP,
  parameter int H_SYNC   = DVI_H_SYNC,
  parameter int H_BP     = DVI_H_BP,
  parameter int V_ACTIVE = DVI_V_ACTIVE,
  parameter int V_FP     = DVI_V_FP,
  parameter int V_SYNC   = DVI_V_SYNC,
  parameter int V_BP     = DVI_V_BP,
  parameter int HW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic          active,
  output logic          hs_on,
  output logic          vs_on,
  output logic          origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VW      = $clog2(V_TOTAL + 1);

  logic [VW-1:0] v_cnt;
  logic          h_wrap;

  assign h_wrap = h_cnt == HW'(H_TOTAL - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
      if (h_wrap)
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
    end
  end

  assign active = (h_cnt < HW'(H_ACTIVE)) &&
                  (v_cnt < VW'(V_ACTIVE));

  assign hs_on = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                 (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));

  assign vs_on = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                 (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

  assign origin = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/dvi_scanout_timing.sv
// Pixel-clock scan-out: raster timing, FIFO pull and registered RGB/sync.
// Optional colour-bar generator built when DVI_TEST_PATTERN_EN is defined.
module dvi_scanout_timing
  import dvi_scanout_timing_pkg::*;
#(
  parameter int          H_ACTIVE        = DVI_H_ACTIVE,
  parameter int          H_FP            = DVI_H_FP,
  parameter int          H_SYNC          = DVI_H_SYNC,
  parameter int          H_BP            = DVI_H_BP,
  parameter int          V_ACTIVE        = DVI_V_ACTIVE,
  parameter int          V_FP            = DVI_V_FP,
  parameter int          V_SYNC          = DVI_V_SYNC,
  parameter int          V_BP            = DVI_V_BP,
  parameter logic        SYNC_POL        = DVI_SYNC_POL,
  parameter logic [23:0] UNDERFLOW_COLOR = DVI_UNDERFLOW_COLOR
) (
  input  logic                 clk_dvi,
  input  logic                 rst_n,
  input  logic                 framebuffer_ready,
  dvi_scanout_timing_if.slave  fb,
  input  logic                 underflow_clr,
`ifdef DVI_TEST_PATTERN_EN
  input  logic                 test_pattern_sel,
`endif
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [23:0]          rgb,
  output logic                 frame_start,
  output logic [15:0]          underflow_count
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1);

  logic [HW-1:0]  h_cnt;
  logic           active, hs_on, vs_on, origin;
  logic           ready_meta, ready_sync;
  scanout_state_t state, state_nx;
  logic           streaming, pix_due, underflow;
  logic           pattern_now;
  rgb_t           pattern_rgb, rgb_nx;
  logic           unused_hi;

  dvi_scanout_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW)
  ) u_counter (
    .clk    (clk_dvi),
    .rst_n  (rst_n),
    .h_cnt  (h_cnt),
    .active (active),
    .hs_on  (hs_on),
    .vs_on  (vs_on),
    .origin (origin)
  );

  assign unused_hi = ^fb.framebuffer_data[31:24];

  always_ff @(posedge clk_dvi) begin
    if (!rst_n) {ready_sync, ready_meta} <= 2'b00;
    else        {ready_sync, ready_meta} <= {ready_meta, framebuffer_ready};
  end

`ifdef DVI_TEST_PATTERN_EN
  logic       pattern_on;
  logic [2:0] bar;

  // Selection only changes at the raster origin so a frame is never split.
  always_ff @(posedge clk_dvi) begin
    if (!rst_n)      pattern_on <= 1'b0;
    else if (origin) pattern_on <= test_pattern_sel;
  end

  assign pattern_now = origin ? test_pattern_sel : pattern_on;
  assign bar         = 3'((32'(h_cnt) * 8) / H_ACTIVE);
  assign pattern_rgb = active ? bar_color(bar) : '0;
`else
  logic unused_h;
  assign unused_h    = ^h_cnt;
  assign pattern_now = 1'b0;
  assign pattern_rgb = '0;
`endif

  always_ff @(posedge clk_dvi) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ready_sync) state_nx = ARMED;
      ARMED:   if (origin)     state_nx = STREAM;
      STREAM:                  state_nx = STREAM;
      default:                 state_nx = IDLE;
    endcase
  end

  // The ARMED->STREAM cycle already streams so pixel (0,0) is popped.
  always_comb begin
    streaming = (state == STREAM) || ((state == ARMED) && origin);
    pix_due   = streaming && active && !pattern_now;
    underflow = pix_due && !fb.framebuffer_valid;
    rgb_nx    = '0;
    if (pattern_now)
      rgb_nx = pattern_rgb;
    else if (pix_due)
      rgb_nx = fb.framebuffer_valid ? rgb_t'(fb.framebuffer_data[23:0])
                                    : rgb_t'(UNDERFLOW_COLOR);
  end

  assign fb.framebuffer_pull = pix_due && fb.framebuffer_valid;

  always_ff @(posedge clk_dvi) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      de          <= active;
      rgb         <= rgb_nx;
      frame_start <= streaming && origin;
    end
  end

  always_ff @(posedge clk_dvi) begin
    if (!rst_n)
      underflow_count <= '0;
    else if (underflow_clr)
      underflow_count <= '0;
    else if (underflow && (underflow_count != 16'hFFFF))
      underflow_count <= underflow_count + 16'd1;
  end

endmodule

// File: tb/tb_dvi_scanout_timing.sv
// Bench for dvi_scanout_timing: phase table with a raster/FIFO reference
// model, hand-written corner sequences and a saturation instance.
module tb_dvi_scanout_timing;

  localparam int HA = 8, HT = 16, VA = 4, VT = 8, FT = HT * VT;
  localparam int SA = 64, SH = 67, SF = SH * SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n, ready, clr;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;
  logic [15:0] ucnt;
  logic        hs2, vs2, de2, fs2;
  logic [23:0] rgb2;
  logic [15:0] ucnt2;

  dvi_scanout_timing_if fb ();
  dvi_scanout_timing_if fb2 ();

  dvi_scanout_timing #(
    .H_ACTIVE (HA), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (VA), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b0), .UNDERFLOW_COLOR (24'hFF00FF)
  ) dut (
    .clk_dvi           (clk),
    .rst_n             (rst_n),
    .framebuffer_ready (ready),
    .fb                (fb),
    .underflow_clr     (clr),
`ifdef DVI_TEST_PATTERN_EN
    .test_pattern_sel  (1'b0),
`endif
    .hsync             (hsync),
    .vsync             (vsync),
    .de                (de),
    .rgb               (rgb),
    .frame_start       (frame_start),
    .underflow_count   (ucnt)
  );

  dvi_scanout_timing #(
    .H_ACTIVE (SA), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE (SA), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dut_sat (
    .clk_dvi           (clk),
    .rst_n             (rst2_n),
    .framebuffer_ready (1'b1),
    .fb                (fb2),
    .underflow_clr     (1'b0),
`ifdef DVI_TEST_PATTERN_EN
    .test_pattern_sel  (1'b0),
`endif
    .hsync             (hs2),
    .vsync             (vs2),
    .de                (de2),
    .rgb               (rgb2),
    .frame_start       (fs2),
    .underflow_count   (ucnt2)
  );

  typedef struct {
    int cycles;
    bit rdy;
    int vpct;
    int cpct;
    int exp_pulls;
    int exp_fs;
  } phase_t;

  int n_cmp = 0, n_bad = 0;
  int n, ready_cyc, model_idx, fifo_idx, exp_cnt;
  int ph_pulls, ph_fs, uf_seen;
  bit sat_done = 0;
  int sat_pulls = 0;
  logic [15:0] sat_mid, sat_end;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, n);
    end
  endtask

  // One pixel clock: drive inputs, predict from raster arithmetic, check.
  task automatic step(input bit rdy, input bit vld, input bit cl,
                      input bit rst);
    int h, v;
    bit act, strm, xp, e_fs;
    logic [23:0] e_rgb;
    ready = rdy;
    clr   = cl;
    rst_n = !rst;
    fb.framebuffer_valid = vld;
    fb.framebuffer_data  = {8'($urandom), 24'(32'h112233 + fifo_idx)};
    h   = n % HT;
    v   = (n / HT) % VT;
    act = (h < HA) && (v < VA);
    if (rdy && ready_cyc < 0) ready_cyc = n;
    strm = (ready_cyc >= 0) && (n >= ((ready_cyc + 3 + FT - 1) / FT) * FT);
    xp   = strm && act && vld;
    #1;
    if (!rst) chk("pull", fb.framebuffer_pull, xp);
    if (fb.framebuffer_pull === 1'b1) begin
      fifo_idx++;
      ph_pulls++;
    end
    e_rgb = !(strm && act) ? 24'h0 :
            vld ? 24'(32'h112233 + model_idx) : 24'hFF00FF;
    e_fs  = strm && (h == 0) && (v == 0);
    if (cl) exp_cnt = 0;
    else if (strm && act && !vld && exp_cnt < 65535) exp_cnt++;
    if (xp) model_idx++;
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_de", de, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_underflow_count", ucnt, 0);
      n = 0;
      ready_cyc = -1;
      exp_cnt = 0;
    end else begin
      chk("de", de, act);
      chk("hsync", hsync, !(h >= 10 && h < 13));
      chk("vsync", vsync, !(v >= 5 && v < 7));
      chk("rgb", rgb, e_rgb);
      chk("frame_start", frame_start, e_fs);
      chk("underflow_count", ucnt, exp_cnt);
      if (frame_start === 1'b1) ph_fs++;
      if (rgb === 24'hFF00FF) uf_seen++;
      n++;
    end
  endtask

  initial begin
    rst2_n = 1'b0;
    fb2.framebuffer_valid = 1'b0;
    fb2.framebuffer_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst2_n = 1'b1;
    for (int k = 0; k < 17 * SF + 10; k++) begin
      @(posedge clk);
      #2;
      if (fb2.framebuffer_pull !== 1'b0) sat_pulls++;
      if (k == 16 * SF - 1) sat_mid = ucnt2;
    end
    sat_end  = ucnt2;
    sat_done = 1'b1;
  end

  initial begin
    phase_t tbl[6];
    int hh, vv;
    tbl[0] = '{384, 1'b0, 100, 0, 0, 0};
    tbl[1] = '{40, 1'b0, 100, 0, 0, 0};
    tbl[2] = '{216, 1'b1, 100, 0, 32, 1};
    tbl[3] = '{256, 1'b1, 100, 0, 64, 2};
    tbl[4] = '{512, 1'b1, 75, 10, -1, 4};
    tbl[5] = '{256, 1'b0, 60, 0, -1, 2};

    n = 0; ready_cyc = -1; model_idx = 0; fifo_idx = 0; exp_cnt = 0;
    ready = 0; clr = 0; rst_n = 0;
    fb.framebuffer_valid = 1'b1;
    fb.framebuffer_data  = '0;
    @(posedge clk);
    #1;
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);

    foreach (tbl[i]) begin
      ph_pulls = 0;
      ph_fs = 0;
      for (int c = 0; c < tbl[i].cycles; c++)
        step(tbl[i].rdy, $urandom_range(99) < tbl[i].vpct,
             $urandom_range(99) < tbl[i].cpct, 0);
      if (tbl[i].exp_pulls >= 0)
        chk($sformatf("pulls_ph%0d", i), ph_pulls, tbl[i].exp_pulls);
      chk($sformatf("frame_starts_ph%0d", i), ph_fs, tbl[i].exp_fs);
    end

    // Two starved pixels on line 0 after clearing the count.
    ph_pulls = 0;
    uf_seen = 0;
    for (int c = 0; c < FT; c++) begin
      hh = c % HT;
      vv = c / HT;
      step(1, !(vv == 0 && (hh == 3 || hh == 4)), c == 0, 0);
    end
    chk("uf_count_two", ucnt, 2);
    chk("uf_rgb_seen", uf_seen, 2);
    chk("pulls_two_starved", ph_pulls, 30);

    // Clear coinciding with an underflow must win.
    for (int c = 0; c < FT; c++) begin
      step(1, !(c == 2 || c == 3), c == 2, 0);
      if (c == 2) chk("clr_wins", ucnt, 0);
      if (c == 3) chk("uf_after_clr", ucnt, 1);
    end

    // Reset while streaming at h=5, then re-arm from IDLE.
    for (int c = 0; c < 5; c++) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    ph_pulls = 0;
    ph_fs = 0;
    for (int c = 0; c < FT; c++) step(1, 1, 0, 0);
    chk("pulls_after_rst_f0", ph_pulls, 0);
    chk("fs_after_rst_f0", ph_fs, 0);
    ph_pulls = 0;
    ph_fs = 0;
    for (int c = 0; c < FT; c++) step(1, 1, 0, 0);
    chk("pulls_after_rst_f1", ph_pulls, 32);
    chk("fs_after_rst_f1", ph_fs, 1);

    for (int g = 0; g < 100000 && !sat_done; g++) @(posedge clk);
    chk("sat_done", sat_done, 1);
    chk("sat_mid_count", sat_mid, 15 * SA * SA);
    chk("sat_end_count", sat_end, 16'hFFFF);
    chk("sat_no_pulls", sat_pulls, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
